// File: rtl/pipeline_ctrl_if.sv
// Purpose: bundles the stage stall requests, exception inputs and control outputs of pipeline_ctrl.
// Latency: none; the interface holds wires and variables only.
// Backpressure: none; stall requests are level signals and are sampled every cycle.
interface pipeline_ctrl_if;
  logic        stallreq_if;   // fetch waiting on instruction bus
  logic        stallreq_id;   // decode load-use hazard
  logic        stallreq_ex;   // execute multi-cycle op busy
  logic        stallreq_mem;  // memory waiting on data bus
  logic [31:0] excepttype;    // 0 = none, 32'h0E = eret
  logic [31:0] cp0_epc;       // forwarded EPC
  logic        inst_busy;     // instruction-bus transaction in flight
  logic [5:0]  stall;         // per-stage hold, bit0 = pc ... bit5 = wb
  logic        flush;         // clear all pipeline registers
  logic [31:0] new_pc;        // redirect target while flush = 1
  logic        busy;          // controller handling an exception

  // Pipeline side: drives requests, consumes stall/flush/redirect
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype, cp0_epc, inst_busy,
    input  stall, flush, new_pc, busy
  );

  // Controller side
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype, cp0_epc, inst_busy,
    output stall, flush, new_pc, busy
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Purpose: pipeline hazard stall generation plus exception drain/flush/redirect sequencing.
// Latency: stall is combinational in RUN; flush follows one cycle after detection, or one cycle after inst_busy drops.
// Backpressure: an outstanding instruction-bus transaction holds the whole pipe in DRAIN until it completes.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [31:0] EXC_ERET = 32'h0000000E;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] target;      // redirect address captured at detection
  logic        flush_r;
  logic        busy_r;
  logic [31:0] new_pc_r;
  logic [5:0]  stall_c;
  logic        exc_hit;
  logic [31:0] exc_target;

  // An exception is only accepted while running; later ones are ignored
  assign exc_hit    = (state == RUN) && (bus.excepttype != 32'h0);
  // eret returns to the forwarded EPC, everything else enters the common vector
  assign exc_target = (bus.excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;

  // Stall mask: contiguous from the pc upward so the first free stage takes a bubble
  always_comb begin
    stall_c = 6'b000000;
    if (!rst) begin
      case (state)
        RUN: begin
          if (bus.excepttype != 32'h0)  stall_c = 6'b111111;
          else if (bus.stallreq_mem)    stall_c = 6'b011111;
          else if (bus.stallreq_ex)     stall_c = 6'b001111;
          else if (bus.stallreq_id)     stall_c = 6'b000111;
          else if (bus.stallreq_if)     stall_c = 6'b000011;
          else                          stall_c = 6'b000000;
        end
        DRAIN:   stall_c = 6'b111111;
        default: stall_c = 6'b000000;
      endcase
    end
  end

  // Exception sequencer: RUN -> (DRAIN while fetch in flight) -> FLUSH -> RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      target   <= 32'h0;
      flush_r  <= 1'b0;
      busy_r   <= 1'b0;
      new_pc_r <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (exc_hit) begin
            target <= exc_target;
            busy_r <= 1'b1;
            if (bus.inst_busy) begin
              // Cannot abort the fetch; wait for it before redirecting
              state <= DRAIN;
            end else begin
              state    <= FLUSH;
              flush_r  <= 1'b1;
              new_pc_r <= exc_target;
            end
          end
        end
        DRAIN: begin
          if (!bus.inst_busy) begin
            state    <= FLUSH;
            flush_r  <= 1'b1;
            new_pc_r <= target;
          end
        end
        FLUSH: begin
          // Single-cycle flush; redirect address is hidden again afterwards
          state    <= RUN;
          flush_r  <= 1'b0;
          new_pc_r <= 32'h0;
          busy_r   <= 1'b0;
        end
        default: begin
          state    <= RUN;
          flush_r  <= 1'b0;
          new_pc_r <= 32'h0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall  = stall_c;
  assign bus.flush  = flush_r;
  assign bus.new_pc = new_pc_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose: self-checking bench for pipeline_ctrl using a cycle model plus directed literal checks.
// Latency: inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Backpressure: inst_busy is driven directly to exercise the drain path.
module tb_pipeline_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Highest requesting stage index decides how many stages from the pc upward hold
  function automatic logic [5:0] hazard_mask(input logic [3:0] req);
    int top;
    top = -1;
    for (int i = 0; i < 4; i++) if (req[i]) top = i;
    if (top < 0) return 6'b000000;
    return 6'((1 << (top + 2)) - 1);
  endfunction

  // Behavioural model: an accepted exception either waits for the fetch or flushes next cycle
  logic        m_waiting  = 1'b0;
  logic        m_flush_now = 1'b0;
  logic [31:0] m_tgt      = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_waiting   <= 1'b0;
      m_flush_now <= 1'b0;
      m_tgt       <= 32'h0;
    end else if (m_flush_now) begin
      m_flush_now <= 1'b0;
    end else if (m_waiting) begin
      if (!bus.inst_busy) begin
        m_waiting   <= 1'b0;
        m_flush_now <= 1'b1;
      end
    end else if (bus.excepttype != 32'h0) begin
      m_tgt <= (bus.excepttype == 32'hE) ? bus.cp0_epc : VEC;
      if (bus.inst_busy) m_waiting <= 1'b1;
      else               m_flush_now <= 1'b1;
    end
  end

  // Compare process: every cycle outside reset
  always @(negedge clk) begin
    logic [5:0] e_stall;
    if (!rst) begin
      if (m_flush_now)                    e_stall = 6'b000000;
      else if (m_waiting)                 e_stall = 6'b111111;
      else if (bus.excepttype != 32'h0)   e_stall = 6'b111111;
      else e_stall = hazard_mask({bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if});
      check("model_stall",  32'(bus.stall),  32'(e_stall));
      check("model_flush",  32'(bus.flush),  32'(m_flush_now));
      check("model_new_pc", bus.new_pc,      m_flush_now ? m_tgt : 32'h0);
      check("model_busy",   32'(bus.busy),   32'(m_waiting | m_flush_now));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] req, input logic [31:0] exc,
                        input logic [31:0] epc, input logic ib);
    bus.stallreq_if  = req[0];
    bus.stallreq_id  = req[1];
    bus.stallreq_ex  = req[2];
    bus.stallreq_mem = req[3];
    bus.excepttype   = exc;
    bus.cp0_epc      = epc;
    bus.inst_busy    = ib;
  endtask

  logic [5:0] lit_stall [5];

  initial begin
    lit_stall[0] = 6'b000011;
    lit_stall[1] = 6'b000111;
    lit_stall[2] = 6'b001111;
    lit_stall[3] = 6'b011111;
    lit_stall[4] = 6'b011111;

    set_in(4'b0000, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    mid();
    check("rst_stall",  32'(bus.stall), 32'h0);
    check("rst_flush",  32'(bus.flush), 32'h0);
    check("rst_new_pc", bus.new_pc,     32'h0);
    check("rst_busy",   32'(bus.busy),  32'h0);

    // Each stall request alone, then all together
    for (int i = 0; i < 5; i++) begin
      step();
      set_in((i < 4) ? 4'(1 << i) : 4'b1111, 32'h0, 32'h0, 1'b0);
      mid();
      check("hazard_stall", 32'(bus.stall), 32'(lit_stall[i]));
      check("hazard_flush", 32'(bus.flush), 32'h0);
    end

    // General exception, fetch idle: flush next cycle; inputs during FLUSH ignored
    step();
    set_in(4'b0000, 32'h8, 32'h0, 1'b0);
    mid();
    check("exc8_stall", 32'(bus.stall), 32'h3F);
    check("exc8_flush", 32'(bus.flush), 32'h0);
    step();
    set_in(4'b1000, 32'h8, 32'h0, 1'b0);
    mid();
    check("exc8_flush1",  32'(bus.flush), 32'h1);
    check("exc8_new_pc",  bus.new_pc,     32'hBFC00380);
    check("exc8_stall0",  32'(bus.stall), 32'h0);
    check("exc8_busy",    32'(bus.busy),  32'h1);
    step();
    set_in(4'b0000, 32'h0, 32'h0, 1'b0);
    mid();
    check("exc8_after_flush",  32'(bus.flush), 32'h0);
    check("exc8_after_new_pc", bus.new_pc,     32'h0);
    check("exc8_after_busy",   32'(bus.busy),  32'h0);

    // eret: EPC captured at detection only
    step();
    set_in(4'b0000, 32'hE, 32'hBFC01234, 1'b0);
    mid();
    check("eret_stall", 32'(bus.stall), 32'h3F);
    step();
    set_in(4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
    mid();
    check("eret_flush",  32'(bus.flush), 32'h1);
    check("eret_new_pc", bus.new_pc,     32'hBFC01234);
    step();
    set_in(4'b0000, 32'h0, 32'h0, 1'b0);

    // Exception with fetch in flight for three cycles
    step();
    set_in(4'b0000, 32'hC, 32'h0, 1'b1);
    mid();
    check("drain_det_stall", 32'(bus.stall), 32'h3F);
    for (int i = 0; i < 3; i++) begin
      step();
      set_in(4'b0000, 32'h0, 32'h0, (i < 2));
      mid();
      check("drain_stall", 32'(bus.stall), 32'h3F);
      check("drain_busy",  32'(bus.busy),  32'h1);
      check("drain_flush", 32'(bus.flush), 32'h0);
    end
    step();
    set_in(4'b0000, 32'h0, 32'h0, 1'b0);
    mid();
    check("drain_flush1", 32'(bus.flush), 32'h1);
    check("drain_new_pc", bus.new_pc,     32'hBFC00380);
    step();
    mid();
    check("drain_flush_once", 32'(bus.flush), 32'h0);

    // Second exception and mem stall during DRAIN are ignored
    step();
    set_in(4'b0000, 32'hC, 32'h0, 1'b1);
    step();
    set_in(4'b1000, 32'hE, 32'h00001111, 1'b1);
    mid();
    check("ign_stall", 32'(bus.stall), 32'h3F);
    check("ign_flush", 32'(bus.flush), 32'h0);
    step();
    set_in(4'b0000, 32'h0, 32'h0, 1'b0);
    mid();
    check("ign_stall2", 32'(bus.stall), 32'h3F);
    step();
    mid();
    check("ign_flush1",  32'(bus.flush), 32'h1);
    check("ign_new_pc",  bus.new_pc,     32'hBFC00380);
    step();
    mid();
    check("ign_flush_once", 32'(bus.flush), 32'h0);
    check("ign_stall_run",  32'(bus.stall), 32'h0);

    // Reset in the middle of DRAIN
    step();
    set_in(4'b0000, 32'h8, 32'h0, 1'b1);
    step();
    set_in(4'b0000, 32'h0, 32'h0, 1'b1);
    mid();
    check("rstdrain_busy_pre", 32'(bus.busy), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(4'b0000, 32'h0, 32'h0, 1'b0);
    mid();
    check("rstdrain_flush",  32'(bus.flush), 32'h0);
    check("rstdrain_busy",   32'(bus.busy),  32'h0);
    check("rstdrain_new_pc", bus.new_pc,     32'h0);
    check("rstdrain_stall",  32'(bus.stall), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      mid();
      check("rstdrain_no_flush", 32'(bus.flush), 32'h0);
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, general exception entry address.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have stallreq_if  input  1  fetch stage waiting on instruction bus.
REQ-005 SHALL have stallreq_id  input  1  decode load-use hazard.
REQ-006 SHALL have stallreq_ex  input  1  execute multi-cycle op (div/madd) busy.
REQ-007 SHALL have stallreq_mem  input  1  memory stage waiting on data bus.
REQ-008 SHALL have excepttype  input  32  encoded exception from mem stage; 0 = none, 32'h0000000E = eret.
REQ-009 SHALL have cp0_epc  input  32  current EPC (forwarded).
REQ-010 SHALL have inst_busy  input  1  instruction-bus transaction outstanding, must not be aborted.
REQ-011 SHALL have stall  output  6  per-stage hold: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = Stop.
REQ-012 SHALL have flush  output  1  registered, clears all pipeline registers.
REQ-013 SHALL have new_pc  output  32  redirect target, valid while flush=1.
REQ-014 SHALL have busy  output  1  high while state != RUN.

Function
REQ-015 SHALL implement FSM states RUN, DRAIN, FLUSH.
REQ-016 RUN, excepttype==0: stall SHALL be combinational from highest-priority request: mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else if -> 6'b000011; else 6'b000000.
REQ-017 Stall patterns SHALL always be contiguous from bit0 upward, so the first non-stalled stage receives a bubble.
REQ-018 RUN, excepttype!=0: stall SHALL be 6'b111111 that cycle; target SHALL be latched (cp0_epc if excepttype==32'h0E, else EXC_VECTOR).
REQ-019 RUN, excepttype!=0: next state SHALL be DRAIN if inst_busy==1, else FLUSH.
REQ-020 DRAIN: stall SHALL be 6'b111111, flush 0; SHALL remain until inst_busy==0, then go to FLUSH.
REQ-021 FLUSH: flush SHALL be 1 for exactly one cycle, new_pc = latched target, stall = 6'b000000; next state RUN.
REQ-022 Exception latency: flush SHALL assert the cycle after detection when inst_busy==0, else the cycle after inst_busy falls.
REQ-023 excepttype and stallreq_* SHALL be ignored in DRAIN and FLUSH; latched target SHALL not change.
REQ-024 cp0_epc SHALL be sampled only at detection; later changes SHALL not affect new_pc.
REQ-025 new_pc SHALL read 32'h0 whenever flush==0.
REQ-026 busy SHALL equal (state==DRAIN || state==FLUSH).

Reset
REQ-027 rst SHALL override all inputs and any state, including mid-DRAIN or FLUSH.
REQ-028 After reset: state RUN, flush 0, new_pc 32'h0, latched target 32'h0, busy 0; stall follows REQ-016 from the next cycle.

Verification
REQ-029 Each stallreq_* alone, then all four together -> stall 000011/000111/001111/011111, all together -> 011111; flush 0.
REQ-030 excepttype=32'h8, inst_busy=0 -> stall 111111 one cycle; next cycle flush=1, new_pc=32'hBFC00380, stall 0; then RUN.
REQ-031 excepttype=32'hE, cp0_epc=32'hBFC01234, cp0_epc changed next cycle -> flush next cycle with new_pc=32'hBFC01234.
REQ-032 excepttype=32'hC with inst_busy=1 for 3 cycles -> stall 111111 and busy=1 throughout, flush=1 the cycle after inst_busy falls, exactly one cycle.
REQ-033 Second exception and stallreq_mem asserted during DRAIN -> ignored; single flush with first target.
REQ-034 rst asserted in DRAIN -> next cycle flush 0, busy 0, new_pc 0; no flush after release.
